// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, bubble instruction and
// the fetch FSM state encoding.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    HOLD = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus used by the fetch unit.
interface if_fetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; anything else
// inserts a bubble that keeps the last PC and presents the NOP encoding.
module if_id_reg #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] instr_r;

  // Prioritised IF/ID update.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_r <= 1'b0;
      pc_r    <= {XLEN{1'b0}};
      instr_r <= NOP_INSTR;
    end else if (flush_i) begin
      valid_r <= 1'b0;
      instr_r <= NOP_INSTR;
    end else if (stall_i) begin
      valid_r <= valid_r;
      pc_r    <= pc_r;
      instr_r <= instr_r;
    end else if (load_i) begin
      valid_r <= 1'b1;
      pc_r    <= pc_i;
      instr_r <= instr_i;
    end else begin
      valid_r <= 1'b0;
      instr_r <= NOP_INSTR;
    end
  end

  assign valid_o = valid_r;
  assign pc_o    = pc_r;
  assign instr_o = instr_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, skid buffer for a
// response that lands during an ID stall, and squashing of flushed fetches.
module if_fetch_unit #(
  parameter int              XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_en_o,
  input  logic            stall_i,
  input  logic            flush_i,
  if_fetch_unit_if.master imem,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_instr_o
);

  cpu_pkg::fetch_state_e state_r;
  logic                  req_r;
  logic                  kill_r;
  logic [XLEN-1:0]       req_pc_r;
  logic [XLEN-1:0]       skid_pc_r;
  logic [XLEN-1:0]       skid_instr_r;

  logic                  drop_s;
  logic                  ifid_stall_s;
  logic                  to_skid_s;
  logic                  load_s;
  logic                  pc_en_s;
  logic [XLEN-1:0]       load_pc_s;
  logic [XLEN-1:0]       load_instr_s;

  assign imem.req  = req_r;
  assign imem.addr = req_pc_r;
  assign pc_en_o   = pc_en_s;

  // Response steering and PC-advance decode; an empty IF/ID never blocks a load.
  always_comb begin
    drop_s       = kill_r | flush_i;
    ifid_stall_s = stall_i & ifid_valid_o;
    pc_en_s      = 1'b0;
    to_skid_s    = 1'b0;
    load_s       = 1'b0;
    load_pc_s    = req_pc_r;
    load_instr_s = imem.rdata;
    case (state_r)
      cpu_pkg::REQ: begin
        pc_en_s = imem.gnt & ~drop_s;
      end
      cpu_pkg::WAIT: begin
        if (imem.rvalid && !drop_s) begin
          if (ifid_stall_s) begin
            to_skid_s = 1'b1;
          end else begin
            load_s = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      cpu_pkg::HOLD: begin
        if (!stall_i && !flush_i) begin
          load_s       = 1'b1;
          load_pc_s    = skid_pc_r;
          load_instr_s = skid_instr_r;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        pc_en_s = 1'b0;
      end
    endcase
  end

  // Fetch FSM; a new request is launched straight from WAIT/HOLD when enabled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r      <= cpu_pkg::IDLE;
      req_r        <= 1'b0;
      kill_r       <= 1'b0;
      req_pc_r     <= {XLEN{1'b0}};
      skid_pc_r    <= {XLEN{1'b0}};
      skid_instr_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        cpu_pkg::IDLE: begin
          if (start_i) begin
            req_pc_r <= pc_i;
            req_r    <= 1'b1;
            state_r  <= cpu_pkg::REQ;
          end else begin
            state_r  <= cpu_pkg::IDLE;
          end
        end
        cpu_pkg::REQ: begin
          if (flush_i) begin
            kill_r <= 1'b1;
          end
          if (imem.gnt) begin
            req_r   <= 1'b0;
            state_r <= cpu_pkg::WAIT;
          end
        end
        cpu_pkg::WAIT: begin
          if (imem.rvalid) begin
            kill_r <= 1'b0;
            if (to_skid_s) begin
              skid_pc_r    <= req_pc_r;
              skid_instr_r <= imem.rdata;
              state_r      <= cpu_pkg::HOLD;
            end else if (start_i) begin
              req_pc_r <= pc_i;
              req_r    <= 1'b1;
              state_r  <= cpu_pkg::REQ;
            end else begin
              state_r  <= cpu_pkg::IDLE;
            end
          end else if (flush_i) begin
            kill_r <= 1'b1;
          end
        end
        cpu_pkg::HOLD: begin
          if (flush_i || !stall_i) begin
            if (start_i) begin
              req_pc_r <= pc_i;
              req_r    <= 1'b1;
              state_r  <= cpu_pkg::REQ;
            end else begin
              state_r  <= cpu_pkg::IDLE;
            end
          end
        end
        default: begin
          state_r <= cpu_pkg::IDLE;
          req_r   <= 1'b0;
          kill_r  <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .stall_i (ifid_stall_s),
    .load_i  (load_s),
    .pc_i    (load_pc_s),
    .instr_i (load_instr_s),
    .valid_o (ifid_valid_o),
    .pc_o    (ifid_pc_o),
    .instr_o (ifid_instr_o)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed cycle-by-cycle bench for if_fetch_unit with hand-computed expectations.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        pc_en_o;
  logic        stall_i;
  logic        flush_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_instr_o;

  int checks;
  int failures;

  if_fetch_unit_if #(.XLEN(32)) imem ();

  if_fetch_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pc_i         (pc_i),
    .pc_en_o      (pc_en_o),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .imem         (imem),
    .ifid_valid_o (ifid_valid_o),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_instr_o (ifid_instr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rd_pc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_pcen;
    logic        e_valid;
    logic [31:0] e_ifpc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic add(input logic st, input logic [31:0] pc, input logic sl, input logic fl,
                     input logic g, input logic rv, input logic [31:0] rd,
                     input logic er, input logic [31:0] ea, input logic ep,
                     input logic ev, input logic [31:0] eif);
    vec_t v;
    v.start = st; v.pc = pc; v.stall = sl; v.flush = fl; v.gnt = g; v.rvalid = rv;
    v.rd_pc = rd; v.e_req = er; v.e_addr = ea; v.e_pcen = ep; v.e_valid = ev; v.e_ifpc = eif;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic er, input logic [31:0] ea,
                            input logic ep, input logic ev, input logic [31:0] eif);
    chk({tag, " req"}, {31'd0, imem.req}, {31'd0, er});
    if (er) chk({tag, " addr"}, imem.addr, ea);
    chk({tag, " pc_en"}, {31'd0, pc_en_o}, {31'd0, ep});
    chk({tag, " valid"}, {31'd0, ifid_valid_o}, {31'd0, ev});
    chk({tag, " ifid_pc"}, ifid_pc_o, eif);
    chk({tag, " instr"}, ifid_instr_o, ev ? instr_of(eif) : NOP);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_i = 1'b0; start_i = 1'b0; pc_i = 32'h0; stall_i = 1'b0; flush_i = 1'b0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;

    //   start pc       stl fl gnt rv rd_pc      req addr     pcen val ifid_pc
    add(1, 32'h000, 0, 0, 0, 0, 32'h000,   0, 32'h000, 0, 0, 32'h000);
    add(1, 32'h000, 0, 0, 1, 0, 32'h000,   1, 32'h000, 1, 0, 32'h000);
    add(1, 32'h004, 0, 0, 0, 1, 32'h000,   0, 32'h000, 0, 0, 32'h000);
    add(1, 32'h004, 0, 0, 1, 0, 32'h000,   1, 32'h004, 1, 1, 32'h000);
    add(1, 32'h008, 0, 0, 0, 1, 32'h004,   0, 32'h000, 0, 0, 32'h000);
    add(1, 32'h008, 0, 0, 1, 0, 32'h000,   1, 32'h008, 1, 1, 32'h004);
    add(1, 32'h00C, 0, 0, 0, 1, 32'h008,   0, 32'h000, 0, 0, 32'h004);
    // stall for 3 cycles while the 0xC response lands in the skid
    add(1, 32'h00C, 1, 0, 1, 0, 32'h000,   1, 32'h00C, 1, 1, 32'h008);
    add(1, 32'h010, 1, 0, 0, 1, 32'h00C,   0, 32'h000, 0, 1, 32'h008);
    add(1, 32'h010, 1, 0, 0, 0, 32'h000,   0, 32'h000, 0, 1, 32'h008);
    add(1, 32'h010, 0, 0, 0, 0, 32'h000,   0, 32'h000, 0, 1, 32'h008);
    add(1, 32'h010, 0, 0, 1, 0, 32'h000,   1, 32'h010, 1, 1, 32'h00C);
    // flush in WAIT, response two cycles later is dropped
    add(1, 32'h014, 0, 1, 0, 0, 32'h000,   0, 32'h000, 0, 0, 32'h00C);
    add(1, 32'h040, 0, 0, 0, 0, 32'h000,   0, 32'h000, 0, 0, 32'h00C);
    add(1, 32'h040, 0, 0, 0, 1, 32'h010,   0, 32'h000, 0, 0, 32'h00C);
    add(1, 32'h040, 0, 0, 1, 0, 32'h000,   1, 32'h040, 1, 0, 32'h00C);
    add(1, 32'h044, 0, 0, 0, 1, 32'h040,   0, 32'h000, 0, 0, 32'h00C);
    // flush+stall with gnt: no pc_en, IF/ID invalidated, fetch killed
    add(1, 32'h044, 1, 1, 1, 0, 32'h000,   1, 32'h044, 0, 1, 32'h040);
    add(1, 32'h080, 0, 0, 0, 1, 32'h044,   0, 32'h000, 0, 0, 32'h040);
    add(1, 32'h080, 0, 0, 1, 0, 32'h000,   1, 32'h080, 1, 0, 32'h040);
    // flush coincident with rvalid
    add(1, 32'h100, 0, 1, 0, 1, 32'h080,   0, 32'h000, 0, 0, 32'h040);
    // gnt delayed 5 cycles
    for (int k = 0; k < 5; k++)
      add(1, 32'h100, 0, 0, 0, 0, 32'h000, 1, 32'h100, 0, 0, 32'h040);
    add(1, 32'h100, 0, 0, 1, 0, 32'h000,   1, 32'h100, 1, 0, 32'h040);
    // start falls mid-transaction
    add(0, 32'h104, 0, 0, 0, 0, 32'h000,   0, 32'h000, 0, 0, 32'h040);
    add(0, 32'h104, 0, 0, 0, 1, 32'h100,   0, 32'h000, 0, 0, 32'h040);
    add(0, 32'h104, 0, 0, 0, 0, 32'h000,   0, 32'h000, 0, 1, 32'h100);
    add(0, 32'h104, 0, 0, 0, 0, 32'h000,   0, 32'h000, 0, 0, 32'h100);
    add(1, 32'h104, 0, 0, 0, 0, 32'h000,   0, 32'h000, 0, 0, 32'h100);
    add(1, 32'h104, 0, 0, 1, 0, 32'h000,   1, 32'h104, 1, 0, 32'h100);

    repeat (2) @(negedge clk_i);
    #1;
    check_outs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      start_i = vecs[i].start; pc_i = vecs[i].pc; stall_i = vecs[i].stall;
      flush_i = vecs[i].flush; imem.gnt = vecs[i].gnt; imem.rvalid = vecs[i].rvalid;
      imem.rdata = instr_of(vecs[i].rd_pc);
      #1;
      check_outs($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pcen,
                 vecs[i].e_valid, vecs[i].e_ifpc);
    end

    // Asynchronous reset while waiting for the 0x104 response
    @(negedge clk_i);
    start_i = 1'b1; pc_i = 32'h200; stall_i = 1'b0; flush_i = 1'b0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0;
    #1;
    check_outs("wait_pre_rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h100);
    #1 rst_i = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_outs("rst_release", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    imem.gnt = 1'b1;
    #1;
    check_outs("post_rst_req", 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
    @(negedge clk_i);
    imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = instr_of(32'h200); pc_i = 32'h204;
    #1;
    check_outs("post_rst_wait", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    imem.rvalid = 1'b0;
    #1;
    check_outs("post_rst_ifid", 1'b1, 32'h204, 1'b0, 1'b1, 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
